collision_probe: RTL

COLLISION_PROBE -- requirements
Module: collision_probe

---
 rtl/collision_probe.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/collision_probe.sv
// Eight-point collision probe around a 16x16 character against a 20x15 tile map.
// Define COLLISION_SCREEN_EDGE_EN to make off-screen probe points count as solid.
module collision_probe (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] x_position,
    input  logic [7:0] y_position,
    output logic [8:0] map_addr,
    output logic       map_rd,
    input  logic       map_data,
    output logic       left_blocked,
    output logic       right_blocked,
    output logic       up_blocked,
    output logic       down_blocked,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic signed [9:0] X_LIMIT = 10'sd160;
    localparam logic signed [9:0] Y_LIMIT = 10'sd120;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    // Bit order for shadow and flags: 0 up, 1 down, 2 left, 3 right.
    logic [3:0]  shadow_q, shadow_d;
    logic [3:0]  flags_q, flags_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_dir_q, pend_dir_d;

    logic signed [9:0] px, py;
    logic              oor;
    logic [8:0]        probe_addr;

    function automatic logic signed [9:0] probe_dx(input logic [2:0] k);
        case (k)
            3'd1, 3'd3: probe_dx = 10'sd15;
            3'd4, 3'd5: probe_dx = -10'sd1;
            3'd6, 3'd7: probe_dx = 10'sd16;
            default:    probe_dx = 10'sd0;
        endcase
    endfunction

    function automatic logic signed [9:0] probe_dy(input logic [2:0] k);
        case (k)
            3'd0, 3'd1: probe_dy = -10'sd1;
            3'd2, 3'd3: probe_dy = 10'sd16;
            3'd5, 3'd7: probe_dy = 10'sd15;
            default:    probe_dy = 10'sd0;
        endcase
    endfunction

    // row*20 + col as (row<<4) + (row<<2) + col; only meaningful for on-screen points.
    function automatic logic [8:0] tile_addr(input logic signed [9:0] tx,
                                             input logic signed [9:0] ty);
        logic [6:0] row;
        logic [6:0] col;
        row = ty[9:3];
        col = tx[9:3];
        tile_addr = 9'({row, 4'b0000} + {2'b00, row, 2'b00} + {4'b0000, col});
    endfunction

    function automatic logic out_of_range(input logic signed [9:0] tx,
                                          input logic signed [9:0] ty);
        out_of_range = (tx < 10'sd0) || (tx >= X_LIMIT) ||
                       (ty < 10'sd0) || (ty >= Y_LIMIT);
    endfunction

    always_comb begin
        px         = $signed({2'b00, x_q}) + probe_dx(idx_q);
        py         = $signed({2'b00, y_q}) + probe_dy(idx_q);
        oor        = out_of_range(px, py);
        probe_addr = tile_addr(px, py);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_PROBE;
                    idx_d   = 3'd0;
                end
            end
            S_PROBE: begin
                if (idx_q == 3'd7) begin
                    state_d = S_CAPTURE;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE: begin
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (state_q == S_IDLE && enable) begin
            x_d = x_position;
            y_d = y_position;
        end
    end

    always_comb begin
        map_addr   = 9'd0;
        map_rd     = 1'b0;
        pend_d     = 1'b0;
        pend_dir_d = idx_q[2:1];
        shadow_d   = shadow_q;
        flags_d    = flags_q;

        if (state_q == S_PROBE) begin
            map_addr = probe_addr;
            map_rd   = !oor;
            pend_d   = !oor;
`ifdef COLLISION_SCREEN_EDGE_EN
            if (oor) shadow_d[idx_q[2:1]] = 1'b1;
`endif
        end

        // Read data returns one cycle after its strobe; the last one lands in CAPTURE.
        if (pend_q && map_data) shadow_d[pend_dir_q] = 1'b1;

        if (state_q == S_IDLE && enable) shadow_d = 4'd0;

        // Load from shadow_d so the final probe's data, arriving this cycle, is included.
        if (state_q == S_CAPTURE) flags_d = shadow_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            shadow_q   <= 4'd0;
            flags_q    <= 4'd0;
            pend_q     <= 1'b0;
            pend_dir_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            flags_q    <= flags_d;
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
        end
    end

    always_ff @(posedge clock) begin
        x_q <= x_d;
        y_q <= y_d;
    end

    assign up_blocked    = flags_q[0];
    assign down_blocked  = flags_q[1];
    assign left_blocked  = flags_q[2];
    assign right_blocked = flags_q[3];
    assign done          = (state_q == S_DONE);

endmodule
